// File: rtl/lamp_sequencer_pkg.sv
// Shared definitions for the tail-light lamp sequencer: state encodings,
// sweep patterns and the default step prescaler divide.
package lamp_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LEFT   = 2'd1,
    ST_RIGHT  = 2'd2,
    ST_HAZARD = 2'd3
  } lamp_state_t;

  localparam int DEFAULT_TICK_DIV = 2500000;

  localparam logic [2:0] PAT_STEP0 = 3'b000;
  localparam logic [2:0] PAT_STEP1 = 3'b001;
  localparam logic [2:0] PAT_STEP2 = 3'b011;
  localparam logic [2:0] PAT_STEP3 = 3'b111;

  // Thermometer sweep, innermost lamp first.
  function automatic logic [2:0] step_pattern(input logic [1:0] s);
    case (s)
      2'd0:    step_pattern = PAT_STEP0;
      2'd1:    step_pattern = PAT_STEP1;
      2'd2:    step_pattern = PAT_STEP2;
      default: step_pattern = PAT_STEP3;
    endcase
  endfunction

endpackage

// File: rtl/lamp_sequencer_prescaler.sv
// Step prescaler: counts 0..TICK_DIV-1 while enabled, held at 0 otherwise.
// restart forces the count back to 0 so a new sweep starts on a full step.
module lamp_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       restart,
  output logic       tick,
  output logic [1:0] count
);

  localparam int CW = (TICK_DIV > 4) ? $clog2(TICK_DIV) : 2;

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || restart || !enable) begin
      cnt <= '0;
    end else if (cnt == CW'(TICK_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick  = (cnt == CW'(TICK_DIV - 1));
  assign count = cnt[1:0];

endmodule

// File: rtl/lamp_sequencer.sv
// Tail-light lamp scheduler: arbitrates turn/hazard/brake requests and
// sweeps 3 lamps per side. Optional 25% dim of unlit lamps: LAMP_DIM_EN.
module lamp_sequencer
  import lamp_sequencer_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int LAMPS    = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_left,
  input  logic       req_right,
  input  logic       req_hazard,
  input  logic       req_brake,
  output logic [2:0] lamp_left,
  output logic [2:0] lamp_right,
  output logic [1:0] state,
  output logic [1:0] step,
  output logic       seq_done
);

  lamp_state_t state_q, state_n, target;
  logic [1:0]  step_q, step_n;
  logic        brake_q;
  logic        seq_done_q, seq_done_n;
  logic        restart, presc_en, tick;
  logic [1:0]  count;
  logic [2:0]  pattern;

`ifdef LAMP_DIM_EN
  assign presc_en = 1'b1;
`else
  assign presc_en = (state_q != ST_IDLE);
  logic unused_count;
  assign unused_count = ^count;
`endif

  lamp_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .enable  (presc_en),
    .restart (restart),
    .tick    (tick),
    .count   (count)
  );

  always_comb begin
    target = ST_IDLE;
    if (req_hazard || (req_left && req_right)) target = ST_HAZARD;
    else if (req_left)                         target = ST_LEFT;
    else if (req_right)                        target = ST_RIGHT;
  end

  // Only entry from IDLE and hazard preemption cut a sweep short;
  // every other change waits for the wrap tick.
  always_comb begin
    state_n    = state_q;
    step_n     = step_q;
    restart    = 1'b0;
    seq_done_n = 1'b0;
    if (state_q == ST_IDLE) begin
      if (target != ST_IDLE) begin
        state_n = target;
        step_n  = 2'd0;
        restart = 1'b1;
      end
    end else if (target == ST_HAZARD && state_q != ST_HAZARD) begin
      state_n = ST_HAZARD;
      step_n  = 2'd0;
      restart = 1'b1;
    end else if (tick) begin
      step_n = step_q + 2'd1;
      if (step_q == 2'd3) begin
        seq_done_n = 1'b1;
        state_n    = target;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      step_q     <= 2'd0;
      brake_q    <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      step_q     <= step_n;
      brake_q    <= req_brake;
      seq_done_q <= seq_done_n;
    end
  end

  assign pattern = step_pattern(step_q);

  always_comb begin
    lamp_left  = brake_q ? 3'b111 : 3'b000;
    lamp_right = brake_q ? 3'b111 : 3'b000;
    case (state_q)
      ST_LEFT:   lamp_left = pattern;
      ST_RIGHT:  lamp_right = pattern;
      ST_HAZARD: begin
        lamp_left  = pattern;
        lamp_right = pattern;
      end
      default: ;
    endcase
`ifdef LAMP_DIM_EN
    if (state_q != ST_HAZARD && count == 2'd0) begin
      lamp_left  = 3'b111;
      lamp_right = 3'b111;
    end
`endif
  end

  assign state    = state_q;
  assign step     = step_q;
  assign seq_done = seq_done_q;

endmodule

// File: tb/tb_lamp_sequencer.sv
// Directed bench for lamp_sequencer with TICK_DIV=4 (default build, no dim).
module tb_lamp_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_left = 1'b0, req_right = 1'b0, req_hazard = 1'b0, req_brake = 1'b0;
  logic [2:0] lamp_left, lamp_right;
  logic [1:0] state, step;
  logic       seq_done;

  int errors = 0;
  int checks = 0;

  lamp_sequencer #(.TICK_DIV(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_left   (req_left),
    .req_right  (req_right),
    .req_hazard (req_hazard),
    .req_brake  (req_brake),
    .lamp_left  (lamp_left),
    .lamp_right (lamp_right),
    .state      (state),
    .step       (step),
    .seq_done   (seq_done)
  );

  always #5 clock = ~clock;

  task automatic clk(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [2:0] observed, input logic [2:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  function automatic logic [2:0] thermo(input int s);
    case (s)
      0:       thermo = 3'b000;
      1:       thermo = 3'b001;
      2:       thermo = 3'b011;
      default: thermo = 3'b111;
    endcase
  endfunction

  task automatic check_all(input string tag, input logic [1:0] st, input logic [1:0] sp,
                           input logic [2:0] ll, input logic [2:0] lr, input logic sd);
    check({tag, ".state"}, {1'b0, state}, {1'b0, st});
    check({tag, ".step"}, {1'b0, step}, {1'b0, sp});
    check({tag, ".lamp_left"}, lamp_left, ll);
    check({tag, ".lamp_right"}, lamp_right, lr);
    check({tag, ".seq_done"}, {2'b0, seq_done}, {2'b0, sd});
  endtask

  initial begin
    clk(2);
    check_all("reset", 2'd0, 2'd0, 3'b000, 3'b000, 1'b0);
    reset = 1'b0;
    clk(2);
    check_all("idle_hold", 2'd0, 2'd0, 3'b000, 3'b000, 1'b0);

    // 1: left sweep, 4 cycles per step, wrap pulse
    req_left = 1'b1;
    clk(1);
    for (int i = 0; i < 16; i++) begin
      check_all($sformatf("t1.c%0d", i), 2'd1, 2'(i / 4), thermo(i / 4), 3'b000, 1'b0);
      clk(1);
    end
    check_all("t1.wrap", 2'd1, 2'd0, 3'b000, 3'b000, 1'b1);
    clk(1);
    check("t1.done_one_cycle", {2'b0, seq_done}, 3'b000);

    // 2: drop left at step 1; sweep completes then IDLE
    clk(3);
    check("t2.at_step1", {1'b0, step}, 3'd1);
    req_left = 1'b0;
    clk(11);
    check_all("t2.last", 2'd1, 2'd3, 3'b111, 3'b000, 1'b0);
    clk(1);
    check_all("t2.to_idle", 2'd0, 2'd0, 3'b000, 3'b000, 1'b1);
    clk(1);
    check_all("t2.idle", 2'd0, 2'd0, 3'b000, 3'b000, 1'b0);

    // 3: hazard preempts left at step 2
    req_left = 1'b1;
    clk(1);
    clk(8);
    check_all("t3.left_s2", 2'd1, 2'd2, 3'b011, 3'b000, 1'b0);
    req_hazard = 1'b1;
    clk(1);
    check_all("t3.preempt", 2'd3, 2'd0, 3'b000, 3'b000, 1'b0);
    clk(4);
    check_all("t3.both_s1", 2'd3, 2'd1, 3'b001, 3'b001, 1'b0);
    req_hazard = 1'b0;
    req_left = 1'b0;
    clk(11);
    check_all("t3.hz_last", 2'd3, 2'd3, 3'b111, 3'b111, 1'b0);
    clk(1);
    check_all("t3.to_idle", 2'd0, 2'd0, 3'b000, 3'b000, 1'b1);

    // 4: brake on the non-sequencing side
    req_left = 1'b1;
    clk(1);
    req_brake = 1'b1;
    clk(2);
    check_all("t4.brake_on", 2'd1, 2'd0, 3'b000, 3'b111, 1'b0);
    clk(2);
    check_all("t4.sweep_on", 2'd1, 2'd1, 3'b001, 3'b111, 1'b0);
    req_brake = 1'b0;
    clk(1);
    check_all("t4.brake_off", 2'd1, 2'd1, 3'b001, 3'b000, 1'b0);
    req_left = 1'b0;
    clk(10);
    check("t4.pre_idle", {1'b0, state}, 3'd1);
    clk(1);
    check("t4.idle", {1'b0, state}, 3'd0);

    // 5: left+right means hazard; right->left waits for wrap
    req_left = 1'b1;
    req_right = 1'b1;
    clk(1);
    check_all("t5.both_hz", 2'd3, 2'd0, 3'b000, 3'b000, 1'b0);
    req_left = 1'b0;
    req_right = 1'b0;
    req_brake = 1'b1;
    clk(16);
    check_all("t5.hz_done", 2'd0, 2'd0, 3'b111, 3'b111, 1'b1);
    req_brake = 1'b0;
    req_right = 1'b1;
    clk(1);
    check_all("t5.right", 2'd2, 2'd0, 3'b000, 3'b000, 1'b0);
    clk(4);
    req_right = 1'b0;
    req_left = 1'b1;
    clk(11);
    check_all("t5.no_switch", 2'd2, 2'd3, 3'b000, 3'b111, 1'b0);
    clk(1);
    check_all("t5.switch", 2'd1, 2'd0, 3'b000, 3'b000, 1'b1);

    // 6: reset mid-hazard, request still held
    req_hazard = 1'b1;
    clk(1);
    clk(8);
    check_all("t6.hz_s2", 2'd3, 2'd2, 3'b011, 3'b011, 1'b0);
    reset = 1'b1;
    clk(1);
    check_all("t6.reset", 2'd0, 2'd0, 3'b000, 3'b000, 1'b0);
    reset = 1'b0;
    clk(1);
    check_all("t6.reenter", 2'd3, 2'd0, 3'b000, 3'b000, 1'b0);
    clk(4);
    check_all("t6.step1", 2'd3, 2'd1, 3'b001, 3'b001, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
